// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP image server: state encoding, size defaults
// and the {row,col} address packing helper.
package lbp_pkg;

  localparam int IMG_W_DEF     = 128;
  localparam int ADDR_W_DEF    = 14;
  localparam int DRAIN_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_SERVE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } srv_state_t;

  function automatic logic [ADDR_W_DEF-1:0] pack_addr(
    input logic [ADDR_W_DEF/2-1:0] row,
    input logic [ADDR_W_DEF/2-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/lbp_sp_ram.sv
// Byte-wide RAM with one synchronous write port and one asynchronous read port.
// Contents are never reset.
module lbp_sp_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lbp_img_server.sv
// Memory-side server for the LBP engine: loads the gray image, serves reads,
// captures lbp writes and dumps the result image. Optional LBP_SRV_CHECK_EN adds write checking.
module lbp_img_server
  import lbp_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_in_valid,
  output logic              pix_in_ready,
  input  logic [7:0]        pix_in_data,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic              gray_ready,
  output logic [7:0]        gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [7:0]        lbp_data,
  input  logic              finish,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic [7:0]        res_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              done,
`ifdef LBP_SRV_CHECK_EN
  output logic              err_dup,
  output logic              err_miss,
`endif
  output logic [2:0]        dbg_state
);

  localparam int N = IMG_W * IMG_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);

  // Streams transfer a beat on a rising edge where valid and ready are both 1;
  // the source holds valid and data stable until that edge.
  srv_state_t        state, next_state;
  logic [ADDR_W-1:0] load_cnt;
  logic [7:0]        drain_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              have_last;
  logic [7:0]        gray_rd, res_rd;
  logic              pix_beat, res_beat, wr_en, wr_inc;

  assign pix_beat  = pix_in_valid & pix_in_ready;
  assign res_beat  = res_valid & res_ready;
  assign wr_en     = lbp_valid & ((state == ST_SERVE) | (state == ST_DRAIN));
  assign dbg_state = state;

  lbp_sp_ram #(.ADDR_W(ADDR_W)) u_gray_ram (
    .clk   (clk),
    .we    (pix_beat),
    .waddr (load_cnt),
    .wdata (pix_in_data),
    .raddr (gray_addr),
    .rdata (gray_rd)
  );

  lbp_sp_ram #(.ADDR_W(ADDR_W)) u_res_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (lbp_addr),
    .wdata (lbp_data),
    .raddr (res_addr),
    .rdata (res_rd)
  );

  assign gray_data = (gray_ready & gray_req) ? gray_rd : 8'h00;
  assign res_data  = res_valid ? res_rd : 8'h00;

  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD:  if (pix_beat && load_cnt == LAST_ADDR) next_state = ST_SERVE;
      ST_SERVE: if (finish) next_state = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) next_state = ST_DUMP;
      ST_DUMP:  if (res_beat && res_addr == LAST_ADDR) next_state = ST_DONE;
      ST_DONE:  next_state = ST_DONE;
      default:  next_state = ST_LOAD;
    endcase
  end

`ifdef LBP_SRV_CHECK_EN
  logic [N-1:0] written;
  logic         prev_wr;
  logic         dup_hit, miss_hit;

  // A repeat is only legal as a continuation of the write held on the previous cycle.
  assign wr_inc   = wr_en & ~written[lbp_addr];
  assign dup_hit  = wr_en & written[lbp_addr] & ~(prev_wr & (last_addr == lbp_addr));
  assign miss_hit = (state == ST_DRAIN) & (next_state == ST_DUMP) &
                    ~&(written | (wr_en ? ({{(N-1){1'b0}}, 1'b1} << lbp_addr) : '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      written  <= '0;
      prev_wr  <= 1'b0;
      err_dup  <= 1'b0;
      err_miss <= 1'b0;
    end else begin
      prev_wr <= wr_en;
      if (wr_en) written[lbp_addr] <= 1'b1;
      if (dup_hit) err_dup <= 1'b1;
      if (miss_hit) err_miss <= 1'b1;
    end
  end
`else
  assign wr_inc = wr_en & (~have_last | (lbp_addr != last_addr));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_LOAD;
      pix_in_ready <= 1'b0;
      gray_ready   <= 1'b0;
      res_valid    <= 1'b0;
      done         <= 1'b0;
      load_cnt     <= '0;
      drain_cnt    <= '0;
      res_addr     <= '0;
      wr_count     <= '0;
      last_addr    <= '0;
      have_last    <= 1'b0;
    end else begin
      state        <= next_state;
      pix_in_ready <= (next_state == ST_LOAD);
      gray_ready   <= (next_state != ST_LOAD);
      res_valid    <= (next_state == ST_DUMP);
      done         <= (next_state == ST_DONE);
      if (pix_beat) load_cnt <= load_cnt + 1'b1;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : 8'd0;
      // The final address ends the dump; it is never incremented past.
      if (res_beat && res_addr != LAST_ADDR) res_addr <= res_addr + 1'b1;
      if (wr_en) begin
        last_addr <= lbp_addr;
        have_last <= 1'b1;
      end
      if (wr_inc) wr_count <= wr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lbp_img_server.sv
// Bench for lbp_img_server: image-level model (gray/result arrays, write counter,
// expected dump address) checked every cycle, plus literal anchors.
module tb_lbp_img_server;
  import lbp_pkg::*;

  localparam int N = 16384;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_in_valid = 1'b0;
  logic        pix_in_ready;
  logic [7:0]  pix_in_data = '0;
  logic        gray_req = 1'b0;
  logic [13:0] gray_addr = '0;
  logic        gray_ready;
  logic [7:0]  gray_data;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr = '0;
  logic [7:0]  lbp_data = '0;
  logic        finish = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [13:0] res_addr;
  logic [7:0]  res_data;
  logic [14:0] wr_count;
  logic        done;
  logic [2:0]  dbg_state;

  lbp_img_server dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pix_in_valid (pix_in_valid),
    .pix_in_ready (pix_in_ready),
    .pix_in_data  (pix_in_data),
    .gray_req     (gray_req),
    .gray_addr    (gray_addr),
    .gray_ready   (gray_ready),
    .gray_data    (gray_data),
    .lbp_valid    (lbp_valid),
    .lbp_addr     (lbp_addr),
    .lbp_data     (lbp_data),
    .finish       (finish),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_addr     (res_addr),
    .res_data     (res_data),
    .wr_count     (wr_count),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model & scoreboard state ----------------
  logic [7:0]  gray_m [N];
  logic [7:0]  res_m  [N];
  bit          res_w  [N];
  int          wr_cnt_m = 0;
  bit          have_last_m = 0;
  logic [13:0] last_m = '0;
  int          exp_next = 0;
  logic [31:0] exp_q[$];
  bit          gray_on = 0, wr_on = 0, dump_on = 0;
  bit          stall_prev = 0;
  logic [13:0] stall_a;
  logic [7:0]  stall_d;
  int          n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (gray_on) begin
        if (gray_req) check("gray_rd", gray_data, gray_m[gray_addr]);
        else          check("gray_idle", gray_data, 8'h00);
      end
      if (wr_on) check("wr_count", wr_count, wr_cnt_m);
      if (dump_on && res_valid) begin
        exp_q.push_back(exp_next);
        check("res_addr", res_addr, exp_q.pop_front());
        if (res_w[res_addr]) check("res_data", res_data, res_m[res_addr]);
        if (stall_prev) begin
          check("stall_addr", res_addr, stall_a);
          check("stall_data", res_data, stall_d);
        end
        if (res_addr == 14'h0102 && res_ready) check("lit_0102", res_data, 8'hA5);
        if (res_addr == 14'h0005 && res_ready) check("lit_0005", res_data, 8'h5A);
        if (res_addr == 14'h3FFF && res_ready) check("lit_3fff", res_data, 8'h11);
        if (res_ready) begin
          exp_next++;
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          stall_a = res_addr;
          stall_d = res_data;
        end
      end
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic write_beat(input logic [13:0] a, input logic [7:0] d);
    lbp_valid = 1'b1;
    lbp_addr  = a;
    lbp_data  = d;
    @(posedge clk);
    res_m[a] = d;
    res_w[a] = 1;
    if (!have_last_m || a != last_m) wr_cnt_m++;
    have_last_m = 1;
    last_m = a;
    #1;
  endtask

  task automatic idle_cycle();
    lbp_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input bit toggle, input bit junk_wr);
    int beat = 0;
    int cyc = 0;
    bit v, rdy;
    while (beat < N && cyc < 4 * N) begin
      v = toggle ? ((cyc % 2) == 0) : 1'b1;
      pix_in_valid = v;
      pix_in_data  = gray_m[beat];
      lbp_valid    = junk_wr && (cyc < 100);
      lbp_addr     = 14'h0007;
      lbp_data     = 8'hEE;
      rdy = pix_in_ready;
      if (beat == N - 1 && v && rdy) check("gray_ready_before", gray_ready, 1'b0);
      @(posedge clk);
      if (v && rdy) beat++;
      cyc++;
      #1;
    end
    pix_in_valid = 1'b0;
    lbp_valid = 1'b0;
    check("load_beats", beat, N);
    check("gray_ready_after", gray_ready, 1'b1);
    check("pix_ready_after", pix_in_ready, 1'b0);
    check("serve_state", dbg_state, ST_SERVE);
  endtask

  task automatic random_reads(input int n);
    for (int k = 0; k < n; k++) begin
      gray_req  = ($urandom_range(0, 3) != 0);
      gray_addr = 14'($urandom_range(0, N - 1));
      @(posedge clk);
      #1;
    end
    gray_req = 1'b0;
  endtask

  task automatic reset_model();
    wr_cnt_m = 0;
    have_last_m = 0;
    last_m = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [13:0] a, hist_a;
    logic [7:0]  d;
    int hold, cyc;

    for (int i = 0; i < N; i++) begin
      gray_m[i] = 8'(i);
      res_w[i] = 0;
    end

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_ready", pix_in_ready, 1'b0);
    check("rst_gray_ready", gray_ready, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_wr_count", wr_count, 0);
    check("rst_done", done, 1'b0);
    check("rst_state", dbg_state, ST_LOAD);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("pix_ready_release", pix_in_ready, 1'b1);
    reset_model();
    wr_on = 1;

    // ramp load with toggling valid and writes that must be ignored
    load_image(1'b1, 1'b1);
    gray_on = 1;

    // literal read of {row 1, col 1}
    gray_req = 1'b1;
    gray_addr = pack_addr(7'd1, 7'd1);
    @(negedge clk);
    check("lit_gray_0081", gray_data, 8'h81);
    @(posedge clk);
    #1;
    gray_req = 1'b0;
    @(negedge clk);
    check("lit_gray_idle", gray_data, 8'h00);
    @(posedge clk);
    #1;
    random_reads(200);

    // held write then an address change
    repeat (3) write_beat(14'h0102, 8'hA5);
    write_beat(14'h0103, 8'h3C);
    idle_cycle();
    check("lit_wr_count", wr_count, 2);
    check("model_wr_count", wr_cnt_m, 2);
    write_beat(14'h0005, 8'h5A);
    hist_a = 14'h0200;
    for (int k = 0; k < 300; k++) begin
      a = 14'($urandom_range(8, N - 2));
      if (a == 14'h0102) a = 14'h0200;
      if (k % 7 == 3) a = hist_a;
      if (k == 0) hist_a = a;
      d = 8'($urandom);
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) write_beat(a, d);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    // finish, late write during drain, then dump
    finish = 1'b1;
    @(posedge clk);
    #1;
    check("drain_state", dbg_state, ST_DRAIN);
    write_beat(14'h3FFF, 8'h11);
    lbp_valid = 1'b0;
    check("res_valid_drain", res_valid, 1'b0);
    @(posedge clk);
    #1;
    check("dump_state", dbg_state, ST_DUMP);
    check("res_valid_dump", res_valid, 1'b1);
    exp_next = 0;
    stall_prev = 0;
    dump_on = 1;
    lbp_valid = 1'b1;
    lbp_addr = 14'h0005;
    lbp_data = 8'hC3;
    res_ready = ($urandom_range(0, 9) < 7);
    @(posedge clk);
    #1;
    lbp_valid = 1'b0;
    finish = 1'b0;
    cyc = 0;
    while (!done && cyc < 60000) begin
      res_ready = ($urandom_range(0, 9) < 7);
      if (cyc % 5 == 0) check("gray_ready_dump", gray_ready, 1'b1);
      @(posedge clk);
      #1;
      cyc++;
    end
    dump_on = 0;
    res_ready = 1'b0;
    check("done", done, 1'b1);
    check("dump_beats", exp_next, N);
    check("res_valid_done", res_valid, 1'b0);
    check("done_state", dbg_state, ST_DONE);

    // round 2: fresh reset, random image, partial dump, reset mid-dump
    gray_on = 0;
    wr_on = 0;
    reset_n = 1'b0;
    #3;
    check("rst2_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    reset_model();
    wr_on = 1;
    for (int i = 0; i < N; i++) gray_m[i] = 8'($urandom);
    load_image(1'b0, 1'b0);
    gray_on = 1;
    random_reads(150);
    finish = 1'b1;
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("dump2_start", res_valid, 1'b1);
    res_ready = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check("dump2_progress", res_addr, 20);
    gray_on = 0;
    wr_on = 0;
    gray_req = 1'b1;
    gray_addr = 14'h0010;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_pix_ready", pix_in_ready, 1'b0);
    check("mid_rst_gray_ready", gray_ready, 1'b0);
    check("mid_rst_gray_data", gray_data, 8'h00);
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_res_addr", res_addr, 0);
    check("mid_rst_res_data", res_data, 8'h00);
    check("mid_rst_wr_count", wr_count, 0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_state", dbg_state, ST_LOAD);
    finish = 1'b0;
    res_ready = 1'b0;
    gray_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_pix_ready", pix_in_ready, 1'b1);
    check("rel_gray_ready", gray_ready, 1'b0);
    check("rel_state", dbg_state, ST_LOAD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lbp_img_server.md
Name: lbp_img_server

Overview:
- Memory-side counterpart of the LBP engine's gray-read and lbp-write interfaces.
- Loads a gray image from a pixel stream into an internal gray RAM, then serves the engine's gray_req/gray_addr reads.
- Captures the engine's lbp_valid writes into an internal result RAM.
- After the engine raises finish, streams the result image out in address order.

Parameters:
- IMG_W, 128, image side in pixels; must be a power of 2.
- ADDR_W, 14, log2(IMG_W*IMG_W); address width for both RAMs.
- DRAIN_CYC, 2, cycles writes are still accepted after finish is first seen.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pix_in_valid  in  1  load-stream beat valid.
- pix_in_ready  out  1  load-stream ready.
- pix_in_data  in  8  gray pixel, raster order, address 0 first.
- gray_req  in  1  engine read request.
- gray_addr  in  ADDR_W  engine read address, {row,col}.
- gray_ready  out  1  image loaded, reads allowed.
- gray_data  out  8  read data.
- lbp_valid  in  1  engine write strobe.
- lbp_addr  in  ADDR_W  engine write address.
- lbp_data  in  8  engine write data.
- finish  in  1  engine completion flag (level).
- res_valid  out  1  result-stream beat valid.
- res_ready  in  1  result-stream ready.
- res_addr  out  ADDR_W  result-stream address.
- res_data  out  8  result-stream pixel.
- wr_count  out  ADDR_W+1  distinct lbp writes accepted.
- done  out  1  result dump complete.

Behaviour:
- Reset values:
  - All outputs 0; state LOAD; counters 0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts everything and returns to LOAD.
- LOAD:
  - pix_in_ready=1.
  - Each beat (valid&ready) writes gray RAM at load_cnt, and load_cnt increments.
  - After beat IMG_W*IMG_W-1: state SERVE, pix_in_ready=0 on the next cycle.
- SERVE:
  - gray_ready=1, registered, high from the first SERVE cycle.
  - Reads: gray_data = gray RAM[gray_addr], combinational (asynchronous read).
    - The engine drives the address at edge k and samples at edge k+1, so data must be stable before k+1.
    - When gray_req=0, gray_data=0.
  - Writes: each cycle with lbp_valid=1 writes result RAM[lbp_addr]=lbp_data.
    - The engine may hold lbp_valid high for several cycles on one address; rewrites are idempotent.
    - wr_count increments only when lbp_addr differs from the last written address, or on the first write after reset.
  - lbp_valid in LOAD is ignored.
- finish handling:
  - First cycle finish=1 in SERVE latches fin_seen and starts a drain counter.
  - Writes continue to be accepted for DRAIN_CYC further cycles, because the engine raises finish before its final write.
  - Then state DUMP.
- DUMP:
  - res_valid is registered; res_addr counts 0..N-1; res_data = result RAM[res_addr].
  - On valid&ready, advance to the next address.
  - res_valid stays high and data stays stable while res_ready=0.
  - gray_ready stays 1 and further lbp writes are ignored.
- DONE:
  - Entered after the handshake of address N-1; res_valid=0, done=1, held until reset.
- Address arithmetic is unsigned ADDR_W bits; wrap at N-1 terminates the dump and never loops.

Optional Feature:
- Macro: LBP_SRV_CHECK_EN.
- With the macro defined:
  - Adds an N-bit written bitmap (set on each accepted write) and outputs err_dup (sticky) and err_miss (sticky).
  - err_dup: a write to an already-set address whose previous write was not the immediately preceding write cycle.
  - err_miss: set at DUMP entry if any bitmap bit is 0.
  - wr_count counts bitmap 0->1 transitions.
- Without the macro: no bitmap, no err ports, and wr_count uses the address-change rule above.

Decomposition:
- Shared package lbp_pkg holds:
  - the state encoding (LOAD, SERVE, DRAIN, DUMP, DONE);
  - IMG_W/ADDR_W defaults;
  - a {row,col} address-pack helper.
- One sub-module: lbp_sp_ram, a 1-write 1-async-read byte RAM, instantiated twice (gray and result).

Test Plan:
- Load ramp pixel=addr[7:0] with pix_in_valid toggling every other cycle -> gray_ready rises exactly 1 cycle after the 16384th beat; pix_in_ready=0 after.
- gray_req=1, gray_addr=0x0081 at edge k -> gray_data=0x81 sampled at edge k+1; gray_req=0 -> gray_data=0.
- lbp_valid held 3 cycles at addr 0x0102 data 0xA5, then addr 0x0103 -> wr_count +2; result RAM[0x0102]=0xA5.
- finish rises, then a write to 0x3FFF data 0x11 one cycle later -> the write is captured; DUMP begins after DRAIN_CYC cycles.
- DUMP with res_ready randomly stalled -> 16384 beats, addresses 0..0x3FFF in order, data stable under stall; done=1 after the last beat.
- reset_n pulsed low mid-DUMP -> all outputs 0 immediately, state LOAD, pix_in_ready=1 after release.
